chip_test_sequencer: RTL and testbench
======================================

Name: chip_test_sequencer

Overview:
Top-level controller that shares one test request and result path across N_CHIPS per-chip tester blocks.
- Latches the chip selection on a Start press and issues a one-cycle Run to the selected tester.
- Waits for that tester's Done, with a timeout, then samples its RSLT and acknowledges it with DISP_RSLT.
- Reports a 2-bit status and keeps saturating pass/fail tallies for the display logic.

Parameters:
N_CHIPS, 8, number of attached tester blocks (2..16)
SEL_W, 4, width of Chip_Sel
TIMEOUT_CYC, 1024, max cycles allowed in any wait state
SETTLE_CYC, 2, cycles between seeing Done and sampling RSLT (minimum 1)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-low reset
Start  in  1  level request, e.g. a debounced button; rising edge only is used
Chip_Sel  in  SEL_W  tester index
Run_o  out  N_CHIPS  one-hot Run to the testers
Done_i  in  N_CHIPS  Done from each tester
Rslt_i  in  N_CHIPS  RSLT from each tester
Disp_Rslt_o  out  N_CHIPS  one-hot DISP_RSLT to the testers
Busy  out  1  high in any state except IDLE
Status_Valid  out  1  Status holds a result
Status  out  2  0=PASS, 1=FAIL, 2=TIMEOUT, 3=BAD_SEL
Pass_Count  out  8  saturating count of PASS results
Fail_Count  out  8  saturating count of FAIL and TIMEOUT results

Behaviour:
- Reset is sampled on the Clk edge while low. All outputs go to 0, the state goes to IDLE, and Start_q (the registered copy of Start) is cleared. This applies mid-operation too: Run_o and Disp_Rslt_o drop at that edge.
- Start edge = Start & ~Start_q. Start edges outside IDLE are ignored.
- IDLE, on a Start edge:
  - Status_Valid is cleared.
  - Chip_Sel is latched into sel.
  - If sel >= N_CHIPS: Status=3, Status_Valid=1, stay in IDLE. Counters are unchanged.
  - Else if Done_i[sel]=1 (the tester is stuck in its done state): go to FLUSH.
  - Else: go to LAUNCH.
- FLUSH:
  - Disp_Rslt_o[sel]=1.
  - When Done_i[sel]=0, go to LAUNCH.
  - If the timer reaches TIMEOUT_CYC-1 first, go to REPORT with TIMEOUT.
- LAUNCH: Run_o[sel]=1 for exactly one cycle, the timer is cleared, go to WAIT_DONE.
- WAIT_DONE:
  - All outputs idle except Busy; the timer increments each cycle.
  - When Done_i[sel]=1, go to SETTLE.
  - If timer==TIMEOUT_CYC-1 with no Done, go to REPORT with TIMEOUT. Done and timeout in the same cycle resolves as Done.
- SETTLE:
  - Waits SETTLE_CYC cycles, then latches res = Rslt_i[sel] and goes to RELEASE.
  - Done_i dropping during SETTLE is ignored: the tester's RSLT register is already final.
- RELEASE:
  - Disp_Rslt_o[sel]=1 and the timer is restarted.
  - When Done_i[sel]=0, go to REPORT with PASS if res=1, else FAIL.
  - If the timer reaches TIMEOUT_CYC-1 first, go to REPORT with TIMEOUT.
- REPORT (one cycle):
  - Status is written and Status_Valid=1.
  - Pass_Count or Fail_Count is incremented, saturating at 255.
  - Go to IDLE.
  - Status and Status_Valid hold until the next Start edge or reset.
- Run_o and Disp_Rslt_o are registered, never both high, and at most one bit is ever set.
- Done_i and Rslt_i of unselected chips are ignored throughout.
- The timer is at least clog2(TIMEOUT_CYC) bits wide and is cleared on every state entry.
- Chip_Sel changes after latching have no effect until the next Start edge.
- Start held high produces exactly one run.
- Latency from Start edge to Run_o is 2 cycles: edge detect, then LAUNCH.

Test Plan:
- Model tester 3 passes (Done 10 cycles after Run, RSLT=1). Start with Chip_Sel=3 -> Run_o=0x08 for one cycle; Disp_Rslt_o=0x08 until Done falls; Status=0, Status_Valid=1, Pass_Count=1.
- Tester 5 returns RSLT=0 -> Status=1, Fail_Count=1, Pass_Count unchanged.
- Tester 2 never asserts Done, TIMEOUT_CYC=16 -> WAIT_DONE exits after 16 cycles; Status=2, Disp_Rslt_o never asserted, Fail_Count increments.
- Chip_Sel=12 with N_CHIPS=8 -> no Run_o; Status=3 the next cycle; Busy stays 0; counters unchanged.
- Done_i[1] already high at Start -> Disp_Rslt_o=0x02 until Done falls, then Run_o=0x02 and a normal pass is reported.
- Reset low during WAIT_DONE -> at the next edge all outputs are 0 and the state is IDLE. A Start held high through the reset release does not launch; a new press does. Also hold Start high for 100 cycles -> exactly one Run pulse, and Pass_Count saturates at 255 after 300 passes.

Source files
------------

// File: rtl/chip_test_sequencer.sv
// Shared test sequencer: launches one of N_CHIPS tester blocks over a common
// Run/Done/RSLT handshake, collects its verdict and keeps pass/fail tallies.

module chip_test_sequencer #(
    parameter int N_CHIPS     = 8,
    parameter int SEL_W       = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int SETTLE_CYC  = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [SEL_W-1:0]   Chip_Sel,
    output logic [N_CHIPS-1:0] Run_o,
    input  logic [N_CHIPS-1:0] Done_i,
    input  logic [N_CHIPS-1:0] Rslt_i,
    output logic [N_CHIPS-1:0] Disp_Rslt_o,
    output logic               Busy,
    output logic               Status_Valid,
    output logic [1:0]         Status,
    output logic [7:0]         Pass_Count,
    output logic [7:0]         Fail_Count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_LAUNCH,
        S_WAIT_DONE,
        S_SETTLE,
        S_RELEASE,
        S_REPORT
    } state_e;

    typedef enum logic [1:0] {
        ST_PASS    = 2'd0,
        ST_FAIL    = 2'd1,
        ST_TIMEOUT = 2'd2,
        ST_BAD_SEL = 2'd3
    } status_e;

    localparam int                 TMR_W       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0]   TMR_LAST    = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0]   SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [SEL_W:0]     CHIP_LIMIT  = (SEL_W + 1)'(N_CHIPS);
    localparam logic [N_CHIPS-1:0] ONE_LSB     = N_CHIPS'(1);

    state_e             r_state;
    state_e             w_nextState;
    status_e            r_code;
    status_e            w_code;
    logic [SEL_W-1:0]   r_sel;
    logic [TMR_W-1:0]   r_timer;
    logic               r_startQ;
    logic               r_armed;
    logic               r_res;
    logic               w_startEdge;
    logic               w_inSelValid;
    logic [N_CHIPS-1:0] w_inOh;
    logic [N_CHIPS-1:0] w_selOh;
    logic               w_doneSel;
    logic               w_rsltSel;
    logic               w_timerLast;
    logic [N_CHIPS-1:0] w_runNext;
    logic [N_CHIPS-1:0] w_dispNext;

    // r_armed stays low while Start is still held from before reset, so a
    // button pressed through reset release cannot launch a run.
    assign w_startEdge  = Start & ~r_startQ & r_armed;
    assign w_inSelValid = ({1'b0, Chip_Sel} < CHIP_LIMIT);
    assign w_inOh       = ONE_LSB << Chip_Sel;
    assign w_selOh      = ONE_LSB << r_sel;
    assign w_doneSel    = |(Done_i & w_selOh);
    assign w_rsltSel    = |(Rslt_i & w_selOh);
    assign w_timerLast  = (r_timer == TMR_LAST);
    assign Busy         = (r_state != S_IDLE);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_code      = r_code;
        case (r_state)
            S_IDLE: begin
                if (w_startEdge && w_inSelValid) begin
                    w_nextState = (|(Done_i & w_inOh)) ? S_FLUSH : S_LAUNCH;
                end
            end
            S_FLUSH: begin
                if (!w_doneSel) begin
                    w_nextState = S_LAUNCH;
                end else if (w_timerLast) begin
                    w_nextState = S_REPORT;
                    w_code      = ST_TIMEOUT;
                end
            end
            S_LAUNCH: begin
                w_nextState = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (w_doneSel) begin
                    w_nextState = S_SETTLE;
                end else if (w_timerLast) begin
                    w_nextState = S_REPORT;
                    w_code      = ST_TIMEOUT;
                end
            end
            S_SETTLE: begin
                if (r_timer == SETTLE_LAST) begin
                    w_nextState = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!w_doneSel) begin
                    w_nextState = S_REPORT;
                    w_code      = r_res ? ST_PASS : ST_FAIL;
                end else if (w_timerLast) begin
                    w_nextState = S_REPORT;
                    w_code      = ST_TIMEOUT;
                end
            end
            S_REPORT: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Run and DISP_RSLT are registered from the current state, so they trail
    // LAUNCH/FLUSH/RELEASE by one cycle and can never overlap.
    always_comb begin
        w_runNext  = '0;
        w_dispNext = '0;
        case (r_state)
            S_LAUNCH:           w_runNext  = w_selOh;
            S_FLUSH, S_RELEASE: w_dispNext = w_selOh;
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            Run_o       <= '0;
            Disp_Rslt_o <= '0;
        end else begin
            Run_o       <= w_runNext;
            Disp_Rslt_o <= w_dispNext;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_startQ <= 1'b0;
            r_armed  <= ~Start;
        end else begin
            r_startQ <= Start;
            if (!Start) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_timer <= '0;
        end else if (r_state == S_IDLE || w_nextState != r_state) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_sel  <= '0;
            r_res  <= 1'b0;
            r_code <= ST_PASS;
        end else begin
            r_code <= w_code;
            if (r_state == S_IDLE && w_startEdge) begin
                r_sel <= Chip_Sel;
            end
            if (r_state == S_SETTLE && w_nextState == S_RELEASE) begin
                r_res <= w_rsltSel;
            end
        end
    end

    // Status holds until the next accepted Start edge; tallies saturate at 255.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            Status       <= 2'd0;
            Status_Valid <= 1'b0;
            Pass_Count   <= 8'd0;
            Fail_Count   <= 8'd0;
        end else begin
            if (r_state == S_IDLE && w_startEdge) begin
                if (w_inSelValid) begin
                    Status_Valid <= 1'b0;
                end else begin
                    Status       <= ST_BAD_SEL;
                    Status_Valid <= 1'b1;
                end
            end
            if (r_state == S_REPORT) begin
                Status       <= r_code;
                Status_Valid <= 1'b1;
                if (r_code == ST_PASS) begin
                    if (Pass_Count != 8'hFF) begin
                        Pass_Count <= Pass_Count + 8'd1;
                    end
                end else if (Fail_Count != 8'hFF) begin
                    Fail_Count <= Fail_Count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_chip_test_sequencer.sv
// Bench for chip_test_sequencer: a behavioural tester drives the selected chip,
// other chips get random noise, and each run is scored against a result model.

module tb_chip_test_sequencer;

    localparam int NC = 8;
    localparam int SW = 4;
    localparam int TO = 16;
    localparam int ST = 2;

    typedef enum int {
        M_NORMAL,
        M_NEVER,
        M_PULSE,
        M_NODROP,
        M_FLUSH,
        M_FLUSH_NODROP
    } mode_e;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [SW-1:0] chipSel;
    logic [NC-1:0] run;
    logic [NC-1:0] done;
    logic [NC-1:0] rslt;
    logic [NC-1:0] disp;
    logic          busy;
    logic          statusValid;
    logic [1:0]    status;
    logic [7:0]    passCount;
    logic [7:0]    failCount;

    int checks = 0;
    int errors = 0;
    int mPass  = 0;
    int mFail  = 0;

    int    tgt;
    mode_e tMode;
    bit    tDone;
    bit    tRes;
    bit    tPulse;
    int    tCnt;
    int    tDly;
    int    tDrop;
    int    tDropLeft;

    int tickNo;
    int runCount;
    int dispCount;
    int busyCount;
    int viol;
    int runTick;
    int holdLeft;

    chip_test_sequencer #(
        .N_CHIPS    (NC),
        .SEL_W      (SW),
        .TIMEOUT_CYC(TO),
        .SETTLE_CYC (ST)
    ) dut (
        .Clk         (clk),
        .Reset       (rst_n),
        .Start       (start),
        .Chip_Sel    (chipSel),
        .Run_o       (run),
        .Done_i      (done),
        .Rslt_i      (rslt),
        .Disp_Rslt_o (disp),
        .Busy        (busy),
        .Status_Valid(statusValid),
        .Status      (status),
        .Pass_Count  (passCount),
        .Fail_Count  (failCount)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int satInc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    // One clock: observe outputs at the falling edge, advance the tester, drive inputs.
    task automatic tick();
        logic [NC-1:0] ohT;
        logic          runT;
        logic          dispT;
        @(negedge clk);
        tickNo++;
        ohT   = (tgt < NC) ? (NC'(1) << tgt) : '0;
        runT  = |(run & ohT);
        dispT = |(disp & ohT);
        if (run !== '0) begin
            runCount++;
            if (runTick < 0) runTick = tickNo;
            if (run !== ohT) viol++;
        end
        if (disp !== '0) begin
            dispCount++;
            if (disp !== ohT) viol++;
        end
        if (run !== '0 && disp !== '0) viol++;
        if (busy === 1'b1) busyCount++;

        if (runT && tMode != M_NEVER) begin
            tCnt = tDly;
        end else if (tCnt > 0) begin
            tCnt--;
            if (tCnt == 0) begin
                tDone     = 1'b1;
                tDropLeft = tDrop;
                tPulse    = (tMode == M_PULSE);
            end
        end else if (tPulse) begin
            tDone  = 1'b0;
            tPulse = 1'b0;
        end
        if (tDone && dispT && tMode != M_NODROP && tMode != M_FLUSH_NODROP) begin
            if (tDropLeft == 0) tDone = 1'b0;
            else tDropLeft--;
        end

        done    = NC'($urandom);
        rslt    = NC'($urandom);
        chipSel = SW'($urandom);
        if (tgt < NC) begin
            done[tgt] = tDone;
            rslt[tgt] = tRes;
        end
        if (holdLeft > 0) begin
            holdLeft--;
            if (holdLeft == 0) start = 1'b0;
        end
    endtask

    task automatic applyStimulus(input int sel, input mode_e mode, input int dly,
                                 input bit res, input int drop, input int hold);
        int startTick;
        int waited;
        int expSt;
        int expRuns;
        bit expDisp;
        tgt       = sel;
        tMode     = mode;
        tDly      = dly;
        tRes      = res;
        tDrop     = drop;
        tDropLeft = drop;
        tCnt      = 0;
        tPulse    = 1'b0;
        tDone     = (mode == M_FLUSH || mode == M_FLUSH_NODROP);
        runCount  = 0;
        dispCount = 0;
        busyCount = 0;
        viol      = 0;
        runTick   = -1;
        if (sel < NC) begin
            done[sel] = tDone;
            rslt[sel] = res;
        end
        chipSel   = SW'(sel);
        start     = 1'b1;
        holdLeft  = hold;
        startTick = tickNo;

        tick();
        if (sel < NC) checkOutput("valid_clear", 32'(statusValid), 0);
        waited = 1;
        while (statusValid !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        checkOutput("complete", 32'(statusValid), 1);
        while (holdLeft > 0) tick();
        tick();
        tick();

        // Expected outcome straight from the handshake rules.
        if (sel >= NC) expSt = 3;
        else if (mode == M_NEVER || mode == M_NODROP || mode == M_FLUSH_NODROP) expSt = 2;
        else expSt = res ? 0 : 1;
        if (expSt == 0) mPass = satInc(mPass);
        else if (expSt != 3) mFail = satInc(mFail);
        expRuns = (sel >= NC || mode == M_FLUSH_NODROP) ? 0 : 1;
        expDisp = (sel < NC && mode != M_NEVER);

        checkOutput("status", 32'(status), expSt);
        checkOutput("status_valid", 32'(statusValid), 1);
        checkOutput("pass_count", 32'(passCount), mPass);
        checkOutput("fail_count", 32'(failCount), mFail);
        checkOutput("run_pulses", runCount, expRuns);
        checkOutput("disp_seen", 32'(dispCount > 0), 32'(expDisp));
        checkOutput("onehot_excl", viol, 0);
        checkOutput("idle_after", 32'(busy), 0);
        if (sel >= NC) checkOutput("badsel_busy", busyCount, 0);
        if (sel < NC && mode == M_NEVER) checkOutput("timeout_busy_cycles", busyCount, TO + 2);
        if (sel < NC && mode != M_FLUSH && mode != M_FLUSH_NODROP)
            checkOutput("run_latency", runTick - startTick, 2);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        chipSel  = '0;
        done     = '0;
        rslt     = '0;
        tgt      = 0;
        tMode    = M_NORMAL;
        tDone    = 1'b0;
        tRes     = 1'b0;
        tPulse   = 1'b0;
        tCnt     = 0;
        tDly     = 1;
        tDrop    = 0;
        tDropLeft= 0;
        tickNo   = 0;
        runCount = 0;
        dispCount= 0;
        busyCount= 0;
        viol     = 0;
        runTick  = -1;
        holdLeft = 0;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checkOutput("rst_run", 32'(run), 0);
        checkOutput("rst_disp", 32'(disp), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_valid", 32'(statusValid), 0);
        checkOutput("rst_status", 32'(status), 0);
        checkOutput("rst_pass", 32'(passCount), 0);
        checkOutput("rst_fail", 32'(failCount), 0);
        tick();

        applyStimulus(3, M_NORMAL, 10, 1'b1, 0, 1);
        applyStimulus(5, M_NORMAL, 10, 1'b0, $urandom_range(0, 3), 1);
        applyStimulus(2, M_NEVER, 1, 1'b0, 0, 1);
        applyStimulus(12, M_NORMAL, 5, 1'b1, 0, 1);
        applyStimulus(1, M_FLUSH, $urandom_range(1, 14), 1'b1, $urandom_range(0, 3), 1);
        applyStimulus(NC, M_NORMAL, 5, 1'b1, 0, 3);
        applyStimulus(NC - 1, M_NORMAL, $urandom_range(1, 14), 1'b1, 0, 2);
        applyStimulus($urandom_range(0, NC - 1), M_PULSE, $urandom_range(1, 14), 1'b1, 0, 1);
        applyStimulus($urandom_range(0, NC - 1), M_NODROP, $urandom_range(1, 14), 1'b1, 0, 1);
        applyStimulus($urandom_range(0, NC - 1), M_FLUSH_NODROP, 3, 1'b1, 0, 1);
        applyStimulus(6, M_NORMAL, 7, 1'b1, 2, 100);

        for (int i = 0; i < 24; i++) begin
            applyStimulus($urandom_range(0, 15), mode_e'($urandom_range(0, 5)),
                          $urandom_range(1, 14), 1'($urandom), $urandom_range(0, 3),
                          $urandom_range(1, 30));
        end

        // Reset in the middle of a wait, with Start still held across release.
        tgt = 4; tMode = M_NEVER; tDone = 1'b0; tCnt = 0; tPulse = 1'b0;
        tDly = 1; tRes = 1'b0; tDrop = 0; tDropLeft = 0;
        runCount = 0; dispCount = 0; busyCount = 0; viol = 0; runTick = -1;
        done[4] = 1'b0; chipSel = 4'd4; start = 1'b1; holdLeft = 0;
        repeat (6) tick();
        checkOutput("rstmid_launched", runCount, 1);
        checkOutput("rstmid_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        tick();
        mPass = 0;
        mFail = 0;
        checkOutput("rstmid_run", 32'(run), 0);
        checkOutput("rstmid_disp", 32'(disp), 0);
        checkOutput("rstmid_busy", 32'(busy), 0);
        checkOutput("rstmid_valid", 32'(statusValid), 0);
        checkOutput("rstmid_status", 32'(status), 0);
        checkOutput("rstmid_pass", 32'(passCount), 0);
        checkOutput("rstmid_fail", 32'(failCount), 0);
        rst_n = 1'b1;
        runCount = 0;
        busyCount = 0;
        repeat (10) tick();
        checkOutput("held_start_no_run", runCount, 0);
        checkOutput("held_start_idle", busyCount, 0);
        start = 1'b0;
        tick();
        tick();
        applyStimulus(4, M_NORMAL, 10, 1'b1, 1, 1);

        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, NC - 1), M_NORMAL, $urandom_range(1, 3), 1'b1, 0, 1);
        end
        checkOutput("pass_saturated", 32'(passCount), 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
